// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle of one TMDS channel: component/control inputs and the encoded symbol.
interface tmds_channel_encoder_if;
  logic       i_de;
  logic [1:0] i_ctrl;
  logic [7:0] i_data;
  logic [9:0] o_tmds;

  // Pixel source / timing generator side
  modport master (
    output i_de,
    output i_ctrl,
    output i_data,
    input  o_tmds
  );

  // Encoder side
  modport slave (
    input  i_de,
    input  i_ctrl,
    input  i_data,
    output o_tmds
  );
endinterface

// File: rtl/tmds_channel_encoder.sv
// DVI TMDS 8b/10b channel encoder: two-stage pipeline, one 10-bit symbol per pixel clock.
module tmds_channel_encoder #(
  parameter int unsigned CNT_WIDTH = 5
) (
  input  logic                  hdmi_clk,
  input  logic                  reset,
  tmds_channel_encoder_if.slave bus
);

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 4;
  localparam int unsigned SW = 10;

  localparam logic [SW-1:0] CTRL_00 = 10'h354;
  localparam logic [SW-1:0] CTRL_01 = 10'h0AB;
  localparam logic [SW-1:0] CTRL_10 = 10'h154;
  localparam logic [SW-1:0] CTRL_11 = 10'h2AB;

  localparam logic signed [CNT_WIDTH-1:0] CNT_0 = CNT_WIDTH'(0);
  localparam logic signed [CNT_WIDTH-1:0] CNT_2 = CNT_WIDTH'(2);

  function automatic logic [PW-1:0] popcount8(input logic [DW-1:0] v);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < DW; i++) n = n + PW'(v[i]);
    return n;
  endfunction

  // Stage 1 state
  logic          de_s1;
  logic [1:0]    ctrl_s1;
  logic [DW:0]   qm_s1;

  // Stage 2 state
  logic signed [CNT_WIDTH-1:0] cnt;
  logic [SW-1:0]               tmds_q;

  // Stage 1 combinational: transition-minimising XOR/XNOR chain
  logic [PW-1:0] n1_data;
  logic          use_xnor;
  logic [DW:0]   qm_c;

  // Pick XOR or XNOR chain from the input popcount and build q_m
  always_comb begin
    n1_data  = popcount8(bus.i_data);
    use_xnor = (n1_data > PW'(4)) || ((n1_data == PW'(4)) && !bus.i_data[0]);
    qm_c     = '0;
    qm_c[0]  = bus.i_data[0];
    for (int k = 1; k < DW; k++) begin
      qm_c[k] = use_xnor ? ~(qm_c[k-1] ^ bus.i_data[k]) : (qm_c[k-1] ^ bus.i_data[k]);
    end
    qm_c[DW] = ~use_xnor;
  end

  // Stage 1 register; ignored inputs are zeroed so X on them never reaches stage 2
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      de_s1   <= 1'b0;
      ctrl_s1 <= 2'b00;
      qm_s1   <= '0;
    end else begin
      de_s1   <= bus.i_de;
      ctrl_s1 <= bus.i_de ? 2'b00 : bus.i_ctrl;
      qm_s1   <= bus.i_de ? qm_c : '0;
    end
  end

  // Stage 2 combinational: DC balancing against the running disparity
  logic [PW-1:0]               n1_q;
  logic [PW-1:0]               n0_q;
  logic signed [CNT_WIDTH-1:0] diff;       // N1 - N0
  logic signed [CNT_WIDTH-1:0] bias_one;   // 2*q_m[8]
  logic signed [CNT_WIDTH-1:0] bias_zero;  // 2*~q_m[8]
  logic signed [CNT_WIDTH-1:0] cnt_nx;
  logic [SW-1:0]               tmds_nx;

  // Choose symbol polarity and next disparity
  always_comb begin
    n1_q      = popcount8(qm_s1[DW-1:0]);
    n0_q      = PW'(DW) - n1_q;
    diff      = $signed(CNT_WIDTH'(n1_q)) - $signed(CNT_WIDTH'(n0_q));
    bias_one  = qm_s1[DW] ? CNT_2 : CNT_0;
    bias_zero = qm_s1[DW] ? CNT_0 : CNT_2;
    tmds_nx   = CTRL_00;
    cnt_nx    = CNT_0;
    if (!de_s1) begin
      case (ctrl_s1)
        2'b00:   tmds_nx = CTRL_00;
        2'b01:   tmds_nx = CTRL_01;
        2'b10:   tmds_nx = CTRL_10;
        default: tmds_nx = CTRL_11;
      endcase
      cnt_nx = CNT_0;
    end else if ((cnt == CNT_0) || (n1_q == n0_q)) begin
      tmds_nx = {~qm_s1[DW], qm_s1[DW], qm_s1[DW] ? qm_s1[DW-1:0] : ~qm_s1[DW-1:0]};
      cnt_nx  = qm_s1[DW] ? (cnt + diff) : (cnt - diff);
    end else if (((cnt > CNT_0) && (n1_q > n0_q)) || ((cnt < CNT_0) && (n0_q > n1_q))) begin
      tmds_nx = {1'b1, qm_s1[DW], ~qm_s1[DW-1:0]};
      cnt_nx  = cnt + bias_one - diff;
    end else begin
      tmds_nx = {1'b0, qm_s1[DW], qm_s1[DW-1:0]};
      cnt_nx  = cnt - bias_zero + diff;
    end
  end

  // Stage 2 register: output symbol and running disparity
  always_ff @(posedge hdmi_clk) begin
    if (reset) begin
      cnt    <= CNT_0;
      tmds_q <= CTRL_00;
    end else begin
      cnt    <= cnt_nx;
      tmds_q <= tmds_nx;
    end
  end

  assign bus.o_tmds = tmds_q;

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// Scoreboard bench for tmds_channel_encoder: directed scenarios plus a random soak.
module tb_tmds_channel_encoder;

  logic hdmi_clk = 1'b0;
  logic reset;

  tmds_channel_encoder_if bus ();

  tmds_channel_encoder #(.CNT_WIDTH(5)) dut (
    .hdmi_clk (hdmi_clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 hdmi_clk = ~hdmi_clk;

  int          checks = 0;
  int          errors = 0;
  logic [9:0]  sb[$];
  int          cnt_m = 0;

  // Reference q_m computation
  function automatic logic [8:0] ref_qm(input logic [7:0] d);
    logic [8:0] qm;
    int         ones;
    bit         xn;
    ones  = $countones(d);
    xn    = (ones > 4) || (ones == 4 && d[0] == 1'b0);
    qm    = '0;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = !xn;
    return qm;
  endfunction

  // Reference symbol and disparity update
  function automatic logic [9:0] ref_encode(input logic de, input logic [1:0] ctrl,
                                            input logic [7:0] data, input int cin,
                                            output int cout);
    logic [8:0] qm;
    logic [9:0] sym;
    int         n1;
    int         n0;
    int         q8;
    if (!de) begin
      cout = 0;
      case (ctrl)
        2'b00:   sym = 10'h354;
        2'b01:   sym = 10'h0AB;
        2'b10:   sym = 10'h154;
        default: sym = 10'h2AB;
      endcase
      return sym;
    end
    qm = ref_qm(data);
    n1 = $countones(qm[7:0]);
    n0 = 8 - n1;
    q8 = qm[8] ? 1 : 0;
    if (cin == 0 || n1 == n0) begin
      sym  = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cout = cin + (q8 == 1 ? (n1 - n0) : (n0 - n1));
    end else if ((cin > 0 && n1 > n0) || (cin < 0 && n0 > n1)) begin
      sym  = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + 2 * q8 + (n0 - n1);
    end else begin
      sym  = {1'b0, qm[8], qm[7:0]};
      cout = cin - 2 * (1 - q8) + (n1 - n0);
    end
    return sym;
  endfunction

  // Drive one cycle, push the symbol expected two edges later, wait for the edge
  task automatic cycle(input logic rst, input logic de, input logic [1:0] ctrl,
                       input logic [7:0] data);
    int nc;
    reset      = rst;
    bus.i_de   = de;
    bus.i_ctrl = ctrl;
    bus.i_data = data;
    if (rst) begin
      sb.delete();
      sb.push_back(10'h354);
      sb.push_back(10'h354);
      cnt_m = 0;
    end else begin
      sb.push_back(ref_encode(de, ctrl, data, cnt_m, nc));
      cnt_m = nc;
    end
    @(posedge hdmi_clk);
    #1;
  endtask

  function automatic logic [9:0] pop_exp();
    if (sb.size() == 0) return 10'h3FF ^ bus.o_tmds;
    return sb.pop_front();
  endfunction

  task automatic test_reset();
    logic [9:0] got;
    logic [9:0] exp;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1, 2'b00, 8'hAA);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== 10'h354) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got 0x%03h, expected 0x354", i, got);
      end
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL reset_model[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
    end
    cycle(1'b0, 1'b1, 2'b00, 8'hAA);
    got = bus.o_tmds;
    exp = pop_exp();
    checks++;
    if (got !== 10'h354) begin
      errors++;
      $display("FAIL reset_release: got 0x%03h, expected 0x354", got);
    end
    cycle(1'b0, 1'b0, 2'b00, 8'h00);
    got = bus.o_tmds;
    exp = pop_exp();
    checks++;
    if (got !== 10'h233 || got !== exp) begin
      errors++;
      $display("FAIL reset_first_data: got 0x%03h, expected 0x233 (model 0x%03h)", got, exp);
    end
    cycle(1'b0, 1'b0, 2'b00, 8'h00);
    got = bus.o_tmds;
    exp = pop_exp();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL reset_flush: got 0x%03h, expected 0x%03h", got, exp);
    end
  endtask

  task automatic test_ctrl();
    logic [11:0] stim[6] = '{12'h000, 12'h100, 12'h200, 12'h300, 12'h000, 12'h000};
    int          want[6] = '{-1, 'h354, 'h0AB, 'h154, 'h2AB, 'h354};
    logic [9:0]  got;
    logic [9:0]  exp;
    for (int i = 0; i < 6; i++) begin
      cycle(stim[i][11], stim[i][10], stim[i][9:8], stim[i][7:0]);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ctrl_model[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
      if (want[i] >= 0) begin
        checks++;
        if (got !== 10'(want[i])) begin
          errors++;
          $display("FAIL ctrl_symbol[%0d]: got 0x%03h, expected 0x%03h", i, got, 10'(want[i]));
        end
      end
    end
  endtask

  task automatic test_dc_balance();
    logic [11:0] stim[6] = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h000, 12'h000};
    int          want[6] = '{-1, 'h100, 'h3FF, 'h100, 'h3FF, 'h354};
    logic [9:0]  got;
    logic [9:0]  exp;
    for (int i = 0; i < 6; i++) begin
      cycle(stim[i][11], stim[i][10], stim[i][9:8], stim[i][7:0]);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL dc_model[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
      if (want[i] >= 0) begin
        checks++;
        if (got !== 10'(want[i])) begin
          errors++;
          $display("FAIL dc_symbol[%0d]: got 0x%03h, expected 0x%03h", i, got, 10'(want[i]));
        end
      end
    end
  endtask

  task automatic test_xnor();
    logic [11:0] stim[5] = '{12'h4FF, 12'h000, 12'h400, 12'h000, 12'h000};
    int          want[5] = '{-1, 'h200, 'h354, 'h100, 'h354};
    logic [9:0]  got;
    logic [9:0]  exp;
    for (int i = 0; i < 5; i++) begin
      cycle(stim[i][11], stim[i][10], stim[i][9:8], stim[i][7:0]);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL xnor_model[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
      if (want[i] >= 0) begin
        checks++;
        if (got !== 10'(want[i])) begin
          errors++;
          $display("FAIL xnor_symbol[%0d]: got 0x%03h, expected 0x%03h", i, got, 10'(want[i]));
        end
      end
    end
  endtask

  task automatic test_midline_reset();
    logic [11:0] stim[11] = '{12'h400, 12'h400, 12'h400, 12'h400, 12'h400, 12'hC00,
                              12'h400, 12'h400, 12'h400, 12'h000, 12'h000};
    int          want[11] = '{-1, 'h100, 'h3FF, 'h100, 'h3FF, 'h354, 'h354,
                              'h100, 'h3FF, 'h100, 'h354};
    logic [9:0]  got;
    logic [9:0]  exp;
    for (int i = 0; i < 11; i++) begin
      cycle(stim[i][11], stim[i][10], stim[i][9:8], stim[i][7:0]);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL midreset_model[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
      if (want[i] >= 0) begin
        checks++;
        if (got !== 10'(want[i])) begin
          errors++;
          $display("FAIL midreset_symbol[%0d]: got 0x%03h, expected 0x%03h", i, got, 10'(want[i]));
        end
      end
    end
  endtask

  task automatic test_ignored_inputs();
    logic [11:0] stim[7] = '{12'b0001_xxxx_xxxx, 12'b0011_xxxx_xxxx, 12'b01xx_0011_1100,
                             12'b01xx_1110_0001, 12'b0010_xxxx_xxxx, 12'h000, 12'h000};
    logic [9:0]  got;
    logic [9:0]  exp;
    for (int i = 0; i < 7; i++) begin
      cycle(stim[i][11], stim[i][10], stim[i][9:8], stim[i][7:0]);
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL ignored_inputs[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
    end
  endtask

  task automatic test_soak();
    logic [9:0] got;
    logic [9:0] exp;
    logic       rst;
    logic       de;
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      de  = ($urandom_range(0, 3) != 0);
      cycle(rst, de, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      got = bus.o_tmds;
      exp = pop_exp();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL soak[%0d]: got 0x%03h, expected 0x%03h", i, got, exp);
      end
    end
  endtask

  // Global time bound
  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b1;
    bus.i_de   = 1'b0;
    bus.i_ctrl = 2'b00;
    bus.i_data = 8'h00;
    test_reset();
    test_ctrl();
    test_dc_balance();
    test_xnor();
    test_midline_reset();
    test_ignored_inputs();
    test_soak();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
